// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches ROM words and presents each to the control unit until it retires; owns the PC.
// Define SEQ_STEP_EN to add single-step mode (step input, WAIT_STEP after each retirement).
module instruction_sequencer #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
`ifdef SEQ_STEP_EN
  input  logic               step,
`endif
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               ctrl_hold,
  input  logic               done,
  input  logic               pc_in,
  input  logic               pc_out,
  input  logic [DATA_W-1:0]  bus_in,
  output logic [DATA_W-1:0]  bus_out,
  output logic               bus_out_en,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, HALTED, WAIT_STEP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic done_q;
  logic retire;
  logic unused_bus;
  assign unused_bus = ^bus_in[DATA_W-1:ADDR_W];
  // Falling edge of Done: a multi-cycle Done retires only once.
  assign retire = (state_q == EXEC) & done_q & ~done;
  assign ctrl_hold = (state_q != EXEC) | retire;
  assign prog_addr = pc_q;
  assign instr = instr_q;
  assign pc = pc_q;
  assign halted = state_q == HALTED;
  assign bus_out_en = pc_out & (state_q == EXEC);
  assign bus_out = bus_out_en ? {{(DATA_W-ADDR_W){1'b0}}, pc_q} : '0;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: state_d = (pc_q == HALT_ADDR) ? HALTED : LATCH;
      LATCH: begin
        instr_d = prog_rdata;
        pc_d = pc_q + ADDR_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        pc_d = pc_in ? bus_in[ADDR_W-1:0] : pc_q;
`ifdef SEQ_STEP_EN
        state_d = retire ? WAIT_STEP : EXEC;
`else
        state_d = retire ? FETCH : EXEC;
`endif
      end
      HALTED: begin
        pc_d = run ? '0 : pc_q;
        state_d = run ? FETCH : HALTED;
      end
`ifdef SEQ_STEP_EN
      WAIT_STEP: state_d = step ? FETCH : WAIT_STEP;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      instr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      done_q <= done;
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: drives a ROM model and a scripted control unit against instruction_sequencer.
module tb_instruction_sequencer;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, done = 1'b0, pc_in = 1'b0, pc_out = 1'b0;
  logic [15:0] bus_in = '0, prog_rdata = '0, instr, bus_out;
  logic [7:0] prog_addr, pc;
  logic ctrl_hold, bus_out_en, halted;
`ifdef SEQ_STEP_EN
  logic step = 1'b0;
`endif
  logic [15:0] rom [256];
  typedef struct packed {logic [15:0] instr; logic [7:0] pc;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic [7:0] mpc = '0;
  always #5 clk = ~clk;
  always @(posedge clk) prog_rdata <= rom[prog_addr];
  instruction_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .prog_addr(prog_addr), .prog_rdata(prog_rdata), .instr(instr), .ctrl_hold(ctrl_hold),
    .done(done), .pc_in(pc_in), .pc_out(pc_out), .bus_in(bus_in), .bus_out(bus_out),
    .bus_out_en(bus_out_en), .pc(pc), .halted(halted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask
  task automatic wait_exec();
    exp_t e;
    int k = 0;
    e.instr = rom[mpc];
    e.pc = mpc + 8'd1;
    sb.push_back(e);
    mpc = mpc + 8'd1;
    while (ctrl_hold && k < 8) begin
      tick();
      k++;
    end
    check("exec_latency", k, 2);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("instr", instr, e.instr);
      check("pc_latched", pc, e.pc);
    end
  endtask
  task automatic exec_instr(input int nd, input bit br, input logic [15:0] bv, input bit ldpc);
    wait_exec();
    check("hold_exec", ctrl_hold, 0);
    tick();
    if (ldpc) begin
      pc_out = 1'b1;
      #1;
      check("ldpc_en", bus_out_en, 1);
      check("ldpc_val", bus_out, {8'h00, mpc});
      pc_out = 1'b0;
      #1;
      check("ldpc_off", bus_out_en, 0);
    end
    if (br) begin
      pc_in = 1'b1;
      bus_in = bv;
      tick();
      pc_in = 1'b0;
      bus_in = '0;
      mpc = bv[7:0];
      check("branch_pc", pc, mpc);
    end
    done = 1'b1;
    for (int i = 0; i < nd; i++) begin
      tick();
      check("hold_done", ctrl_hold, 0);
    end
    done = 1'b0;
    #1;
    check("retire_hold", ctrl_hold, 1);
    tick();
`ifdef SEQ_STEP_EN
    repeat (3) tick();
    check("step_wait", ctrl_hold, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
    check("next_fetch", prog_addr, mpc);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    rom[0] = 16'h2000;
    rom[1] = 16'h4001;
    tick();
    tick();
    check("rst_hold", ctrl_hold, 1);
    check("rst_pc", pc, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_en", bus_out_en, 0);
    check("rst_bus", bus_out, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_hold", ctrl_hold, 1);
    pulse_run();
    check("fetch0", prog_addr, 0);
    exec_instr(1, 0, '0, 0);
    exec_instr(2, 0, '0, 0);
    exec_instr(1, 0, '0, 0);
    exec_instr(1, 1, 16'hAB42, 0);
    check("branch_fetch", prog_addr, 8'h42);
    exec_instr(1, 1, 16'h0005, 0);
    exec_instr(1, 0, '0, 1);
    exec_instr(1, 1, 16'hFFFF, 0);
    check("pre_halt", halted, 0);
    tick();
    check("halted", halted, 1);
    check("halt_hold", ctrl_hold, 1);
    repeat (3) tick();
    check("halt_stay", halted, 1);
    pulse_run();
    mpc = '0;
    check("restart_halted", halted, 0);
    check("restart_addr", prog_addr, 0);
    wait_exec();
    reset = 1'b1;
    #1;
    check("async_hold", ctrl_hold, 1);
    check("async_pc", pc, 0);
    check("async_instr", instr, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("idle_no_exec", ctrl_hold, 1);
    check("idle_addr", prog_addr, 0);
    mpc = '0;
    pulse_run();
    exec_instr(2, 0, '0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
